// File: rtl/polar_pkg.sv
// Shared constants, FSM state type and phase-rounding helper for the CORDIC
// gain-correction stage.
package polar_pkg;

    localparam int DEF_MW    = 12;
    localparam int DEF_PW    = 19;
    localparam int DEF_OPW   = 16;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_GW    = 16;

    // round(2^16 / 1.164435): reciprocal of the CORDIC gain
    localparam logic [15:0] GAIN_INV = 16'hDBD9;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        OUT,
        WAIT
    } state_t;

    // Round-half-up to opw bits; the carry out of the top wraps around the circle.
    function automatic logic [31:0] round_phase(input logic [31:0] ph,
                                                input int unsigned pw,
                                                input int unsigned opw);
        logic [31:0] mask;
        logic [31:0] sum;
        mask = (32'd1 << pw) - 32'd1;
        sum  = (ph + (32'd1 << (pw - opw - 1))) & mask;
        return sum >> (pw - opw);
    endfunction

endpackage

// File: rtl/polar_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a counter. DEPTH must be a power of 2, >= 2.
module polar_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 31
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_rd,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic         wr_ok;
    logic         rd_ok;

    assign o_empty = (wr_ptr_reg == rd_ptr_reg);
    assign o_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A simultaneous pop frees the slot, so a write into a full FIFO is still taken.
    assign wr_ok = i_wr && (!o_full || i_rd);
    assign rd_ok = i_rd && !o_empty;

    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/polar_gain_corr.sv
// Removes the CORDIC gain from the magnitude with a bit-serial shift-add
// multiply and rounds the phase, behind a small FIFO and valid/ready output.
module polar_gain_corr
    import polar_pkg::*;
#(
    parameter int MW    = DEF_MW,
    parameter int PW    = DEF_PW,
    parameter int OPW   = DEF_OPW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int GW    = DEF_GW
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_ce,
    input  logic           i_valid,
    input  logic [MW-1:0]  i_mag,
    input  logic [PW-1:0]  i_phase,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [MW-1:0]  o_mag,
    output logic [OPW-1:0] o_phase,
    output logic           o_overflow
);

    localparam int AW = MW + GW;
    localparam int CW = $clog2(GW);
    localparam logic [GW-1:0] K = GW'(GAIN_INV);

    state_t state_reg;
    state_t state_next;

    logic              fifo_wr;
    logic              fifo_full;
    logic              fifo_empty;
    logic [MW+PW-1:0]  fifo_rdata;
    logic [MW-1:0]     head_mag;
    logic [PW-1:0]     head_phase;

    logic              pop;
    logic              load_out;

    logic [AW-1:0]     mult_reg;
    logic [AW-1:0]     acc_reg;
    logic [CW-1:0]     cnt_reg;
    logic [PW-1:0]     ph_reg;
    logic [AW-1:0]     acc_round;

    assign fifo_wr = i_ce && i_valid;

    polar_fifo #(
        .DEPTH (DEPTH),
        .W     (MW + PW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_wr    (fifo_wr),
        .i_wdata ({i_mag, i_phase}),
        .i_rd    (pop),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign head_mag   = fifo_rdata[MW+PW-1:PW];
    assign head_phase = fifo_rdata[PW-1:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // OUT parks a finished result until the output register frees up, so one
    // result can wait in the multiplier while another is held on the output.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        load_out   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                if (cnt_reg == CW'(GW - 1)) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (!o_valid || i_ready) begin
                    load_out   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign acc_round = acc_reg + AW'(1 << (GW - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mult_reg <= '0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            ph_reg   <= '0;
        end else if (pop) begin
            // Negative magnitudes clamp to zero before the multiply.
            mult_reg <= head_mag[MW-1] ? '0 : AW'(head_mag);
            acc_reg  <= '0;
            cnt_reg  <= '0;
            ph_reg   <= head_phase;
        end else if (state_reg == MUL) begin
            if (K[cnt_reg]) begin
                acc_reg <= acc_reg + (mult_reg << cnt_reg);
            end
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_mag   <= '0;
            o_phase <= '0;
        end else if (load_out) begin
            o_valid <= 1'b1;
            o_mag   <= acc_round[AW-1:GW];
            o_phase <= OPW'(round_phase(32'(ph_reg), PW, OPW));
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_overflow <= 1'b0;
        end else if (fifo_wr && fifo_full && !pop) begin
            o_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_polar_gain_corr.sv
// Directed and random checks of polar_gain_corr against an arithmetic
// reference model, with a scoreboard of expected {mag, phase} results.
module tb_polar_gain_corr;

    logic        i_clk;
    logic        i_reset;
    logic        i_ce;
    logic        i_valid;
    logic [11:0] i_mag;
    logic [18:0] i_phase;
    logic        o_valid;
    logic        i_ready;
    logic [11:0] o_mag;
    logic [15:0] o_phase;
    logic        o_overflow;

    polar_gain_corr dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_ce       (i_ce),
        .i_valid    (i_valid),
        .i_mag      (i_mag),
        .i_phase    (i_phase),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_mag      (o_mag),
        .o_phase    (o_phase),
        .o_overflow (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;
    logic [27:0] sb[$];
    int          ready_mode = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [11:0] ref_mag(input logic [11:0] m);
        logic [31:0] prod;
        if (m[11]) return 12'h000;
        prod = 32'(m) * 32'd56281 + 32'd32768;
        return prod[27:16];
    endfunction

    function automatic logic [15:0] ref_ph(input logic [18:0] p);
        logic [19:0] s;
        s = 20'(p) + 20'd4;
        return s[18:3];
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic push(input logic [11:0] m, input logic [18:0] p,
                        input logic [27:0] e, input bit accept);
        i_mag   = m;
        i_phase = p;
        i_ce    = 1'b1;
        i_valid = 1'b1;
        if (accept) sb.push_back(e);
        @(posedge i_clk);
        #1;
        i_ce    = 1'b0;
        i_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int k;
        k = 0;
        while (sb.size() != 0 && k < bound) begin
            tick(1);
            k++;
        end
        check(tag, 32'(sb.size()), 32'd0);
        tick(2);
    endtask

    always @(posedge i_clk) begin
        #1;
        case (ready_mode)
            0:       i_ready = 1'b0;
            1:       i_ready = 1'b1;
            default: i_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: scoreboard compare on transfer, stability while stalled.
    logic        hold_prev = 1'b0;
    logic [11:0] prev_mag;
    logic [15:0] prev_ph;
    logic [27:0] exp_out;

    always @(negedge i_clk) begin
        if (i_reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_stable", {3'b0, o_valid, o_mag, o_phase}, {4'b0001, prev_mag, prev_ph});
            end
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL spurious_out: got mag=%h ph=%h want no output", o_mag, o_phase);
                end else begin
                    exp_out = sb.pop_front();
                    n_out++;
                    $display("out %0d: mag=%h ph=%h exp mag=%h ph=%h",
                             n_out, o_mag, o_phase, exp_out[27:16], exp_out[15:0]);
                    check("out_data", {4'b0, o_mag, o_phase}, {4'b0, exp_out});
                end
            end
            hold_prev = o_valid && !i_ready;
            prev_mag  = o_mag;
            prev_ph   = o_phase;
        end
    end

    initial begin
        int          lat;
        int          g;
        logic [11:0] m;
        logic [18:0] p;

        i_reset = 1'b1;
        i_ce    = 1'b0;
        i_valid = 1'b0;
        i_mag   = '0;
        i_phase = '0;
        i_ready = 1'b1;
        tick(3);
        check("reset_state", {2'b0, o_valid, o_overflow, o_mag, o_phase}, 32'd0);
        i_reset = 1'b0;
        tick(2);

        // Single sample: exact latency and nominal values.
        push(12'h400, 19'h10000, {12'h36F, 16'h2000}, 1'b1);
        lat = 0;
        while (!o_valid && lat < 40) begin
            tick(1);
            lat++;
        end
        check("latency", 32'(lat), 32'd18);
        tick(1);
        check("valid_drop", 32'(o_valid), 32'd0);

        // Full-scale magnitude, then negative clamp with phase wrap.
        push(12'h7FF, 19'h7FFFB, {12'h6DE, 16'hFFFF}, 1'b1);
        push(12'hF00, 19'h7FFFC, {12'h000, 16'h0000}, 1'b1);
        wait_drain("drain_corners", 100);

        // Valid without clock enable must never be captured.
        i_ce    = 1'b0;
        i_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            check("ce_gate", 32'(o_valid), 32'd0);
        end
        i_valid = 1'b0;
        tick(30);
        check("ce_gate_idle", 32'(o_valid), 32'd0);

        // Stalled output: 1 held + 1 in multiplier + 4 buffered, 7th dropped.
        ready_mode = 0;
        tick(2);
        for (int k = 0; k < 7; k++) begin
            if (k == 6) check("ovf_before", 32'(o_overflow), 32'd0);
            m = 12'(k * 12'h100 + 12'h080);
            p = 19'((k + 1) * 8);
            push(m, p, {ref_mag(m), ref_ph(p)}, k < 6);
            tick(24);
        end
        check("ovf_set", 32'(o_overflow), 32'd1);
        ready_mode = 1;
        wait_drain("drain_ovf", 400);
        tick(60);
        check("ovf_sticky", 32'(o_overflow), 32'd1);

        // Reset mid-multiply: async clear, nothing emerges afterwards.
        push(12'h400, 19'h10000, 28'h0, 1'b0);
        tick(9);
        #2;
        i_reset = 1'b1;
        #1;
        check("reset_async", {2'b0, o_valid, o_overflow, o_mag, o_phase}, 32'd0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        sb.delete();
        for (int k = 0; k < 40; k++) begin
            tick(1);
            check("post_reset_idle", 32'(o_valid), 32'd0);
        end

        // Random traffic with random back-pressure; never overfill the FIFO.
        ready_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            g = 0;
            while (sb.size() >= 4 && g < 500) begin
                tick(1);
                g++;
            end
            if (g >= 500) begin
                n_cmp++;
                n_err++;
                $error("FAIL rand_stall: got %0d outstanding want < 4", sb.size());
            end
            m = 12'($urandom);
            p = 19'($urandom);
            push(m, p, {ref_mag(m), ref_ph(p)}, 1'b1);
            tick($urandom_range(0, 3));
        end
        check("ovf_rand", 32'(o_overflow), 32'd0);
        ready_mode = 1;
        wait_drain("drain_rand", 2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
